// File: rtl/csr_trap_seq_pkg.sv
// Shared types and constants for the trap/return sequencer: state encoding, CSR addresses,
// trap causes and mstatus/mie bit positions.
package csr_trap_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      W_MRET,
      JUMP
   } state_e;

   localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

   localparam logic [31:0] CAUSE_ECALL     = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
   localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MIE_MEIE_BIT     = 11;
   localparam int MIE_MTIE_BIT     = 7;

   // Trap entry: MPIE <= MIE, MIE <= 0.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r                   = ms;
      r[MSTATUS_MPIE_BIT] = ms[MSTATUS_MIE_BIT];
      r[MSTATUS_MIE_BIT]  = 1'b0;
      return r;
   endfunction

   // Return: MIE <= MPIE, MPIE <= 1.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r                   = ms;
      r[MSTATUS_MIE_BIT]  = ms[MSTATUS_MPIE_BIT];
      r[MSTATUS_MPIE_BIT] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/csr_trap_seq_cause_enc.sv
// trap_cause_enc: combinational priority encoder ecall > ebreak > mret > ext irq (> timer irq when
// CSR_TRAP_SEQ_TIMER_IRQ_EN is defined); zero latency, no backpressure of its own.
module trap_cause_enc
   import csr_trap_seq_pkg::*;
(
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        mret_i,
   input  logic        irq_i,
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
   input  logic        timer_irq_i,
`endif
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   output logic        accept_o,
   output logic        is_mret_o,
   output logic [31:0] cause_o
);

   logic irq_en;
   logic unused_csr_bits;

   assign irq_en          = mstatus_i[MSTATUS_MIE_BIT];
   assign unused_csr_bits = ^{mstatus_i, mie_i};

   always_comb begin
      accept_o  = 1'b1;
      is_mret_o = 1'b0;
      cause_o   = '0;
      if (ecall_i) begin
         cause_o = CAUSE_ECALL;
      end else if (ebreak_i) begin
         cause_o = CAUSE_EBREAK;
      end else if (mret_i) begin
         is_mret_o = 1'b1;
      end else if (irq_i && irq_en && mie_i[MIE_MEIE_BIT]) begin
         cause_o = CAUSE_EXT_IRQ;
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
      end else if (timer_irq_i && irq_en && mie_i[MIE_MTIE_BIT]) begin
         cause_o = CAUSE_TIMER_IRQ;
`endif
      end else begin
         accept_o = 1'b0;
      end
   end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer: writes mepc, mcause, mstatus then pulses jump (accept N, jump N+4; mret jump N+2).
// Each write holds while exu_csr_we_i owns the CSR port; timer irq port present with CSR_TRAP_SEQ_TIMER_IRQ_EN.
module csr_trap_seq
   import csr_trap_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_ecall_i,
   input  logic        inst_ebreak_i,
   input  logic        inst_mret_i,
   input  logic [31:0] inst_pc_i,
   input  logic        irq_i,
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
   input  logic        timer_irq_i,
`endif
   input  logic        exu_csr_we_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   output logic        csr_we_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        busy_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cause_q, cause_d;
   logic        mret_q, mret_d;

   logic        enc_accept;
   logic        enc_is_mret;
   logic [31:0] enc_cause;
   logic        unused_mtvec_lo;

   assign unused_mtvec_lo = ^mtvec_i[1:0];

   trap_cause_enc u_cause_enc (
      .ecall_i    (inst_ecall_i),
      .ebreak_i   (inst_ebreak_i),
      .mret_i     (inst_mret_i),
      .irq_i      (irq_i),
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
      .timer_irq_i(timer_irq_i),
`endif
      .mstatus_i  (mstatus_i),
      .mie_i      (mie_i),
      .accept_o   (enc_accept),
      .is_mret_o  (enc_is_mret),
      .cause_o    (enc_cause)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         mret_q  <= mret_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cause_d     = cause_q;
      mret_d      = mret_q;
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      busy_o      = 1'b1;
      jump_o      = 1'b0;
      jump_addr_o = RESET_PC;

      unique case (state_q)
         IDLE: begin
            // The pipeline must freeze in the same cycle the event is taken.
            busy_o = enc_accept;
            if (enc_accept) begin
               pc_d    = inst_pc_i;
               cause_d = enc_cause;
               mret_d  = enc_is_mret;
               state_d = enc_is_mret ? W_MRET : W_MEPC;
            end
         end
         W_MEPC: begin
            if (!exu_csr_we_i) begin
               csr_we_o    = 1'b1;
               csr_waddr_o = CSR_MEPC;
               csr_wdata_o = pc_q;
               state_d     = W_MCAUSE;
            end
         end
         W_MCAUSE: begin
            if (!exu_csr_we_i) begin
               csr_we_o    = 1'b1;
               csr_waddr_o = CSR_MCAUSE;
               csr_wdata_o = cause_q;
               state_d     = W_MSTATUS;
            end
         end
         W_MSTATUS: begin
            if (!exu_csr_we_i) begin
               csr_we_o    = 1'b1;
               csr_waddr_o = CSR_MSTATUS;
               csr_wdata_o = trap_mstatus(mstatus_i);
               state_d     = JUMP;
            end
         end
         W_MRET: begin
            if (!exu_csr_we_i) begin
               csr_we_o    = 1'b1;
               csr_waddr_o = CSR_MSTATUS;
               csr_wdata_o = mret_mstatus(mstatus_i);
               state_d     = JUMP;
            end
         end
         JUMP: begin
            jump_o      = 1'b1;
            jump_addr_o = mret_q ? mepc_i : {mtvec_i[31:2], 2'b00};
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: a CSR file fed by the DUT's writes, directed scenarios with literal expectations,
// then random events checked every cycle against an action-queue model.
module tb_csr_trap_seq;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   localparam int K_WR       = 0;
   localparam int K_WR_TRAP  = 1;
   localparam int K_WR_MRET  = 2;
   localparam int K_JMP_TRAP = 3;
   localparam int K_JMP_MRET = 4;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] dat;
   } op_t;

   logic        clk;
   logic        rst_n;
   logic        inst_ecall_i, inst_ebreak_i, inst_mret_i;
   logic [31:0] inst_pc_i;
   logic        irq_i;
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
   logic        timer_irq_i;
`endif
   logic        exu_csr_we_i;
   logic [31:0] exu_dat;
   logic [31:0] mtvec_r, mepc_r, mstatus_r, mie_r, mcause_r;
   logic        preset_req;
   logic [31:0] p_ms, p_mie, p_mtvec, p_mepc;

   logic        csr_we_o;
   logic [31:0] csr_waddr_o, csr_wdata_o;
   logic        busy_o, jump_o;
   logic [31:0] jump_addr_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   csr_trap_seq #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst_ecall_i (inst_ecall_i),
      .inst_ebreak_i(inst_ebreak_i),
      .inst_mret_i  (inst_mret_i),
      .inst_pc_i    (inst_pc_i),
      .irq_i        (irq_i),
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
      .timer_irq_i  (timer_irq_i),
`endif
      .exu_csr_we_i (exu_csr_we_i),
      .mtvec_i      (mtvec_r),
      .mepc_i       (mepc_r),
      .mstatus_i    (mstatus_r),
      .mie_i        (mie_r),
      .csr_we_o     (csr_we_o),
      .csr_waddr_o  (csr_waddr_o),
      .csr_wdata_o  (csr_wdata_o),
      .busy_o       (busy_o),
      .jump_o       (jump_o),
      .jump_addr_o  (jump_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // CSR register file: sequencer writes win, then exu writes (to mstatus), then bench presets.
   always @(posedge clk) begin
      if (csr_we_o) begin
         case (csr_waddr_o)
            32'h300: mstatus_r <= csr_wdata_o;
            32'h341: mepc_r    <= csr_wdata_o;
            32'h342: mcause_r  <= csr_wdata_o;
            default: ;
         endcase
      end else if (exu_csr_we_i) begin
         mstatus_r <= exu_dat;
      end else if (preset_req) begin
         mstatus_r <= p_ms;
         mie_r     <= p_mie;
         mtvec_r   <= p_mtvec;
         mepc_r    <= p_mepc;
      end
   end

   // Reference model: a queue of pending port actions, refilled only when empty.
   op_t ops[$];
   bit  model_on = 1'b0;

   always @(negedge clk) begin
      logic        acc, is_mret, consumed;
      logic [31:0] cause;
      logic        e_we, e_busy, e_jump;
      logic [31:0] e_addr, e_dat, e_jaddr, ms;
      op_t         o;
      acc = 1'b0; is_mret = 1'b0; cause = 32'h0; consumed = 1'b0;
      ms  = mstatus_r;
      if (ops.size() == 0) begin
         if (inst_ecall_i)                          begin acc = 1'b1; cause = 32'd11; end
         else if (inst_ebreak_i)                    begin acc = 1'b1; cause = 32'd3; end
         else if (inst_mret_i)                      begin acc = 1'b1; is_mret = 1'b1; end
         else if (irq_i && ms[3] && mie_r[11])      begin acc = 1'b1; cause = 32'h8000_000B; end
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
         else if (timer_irq_i && ms[3] && mie_r[7]) begin acc = 1'b1; cause = 32'h8000_0007; end
`endif
      end
      e_we = 1'b0; e_addr = 32'h0; e_dat = 32'h0; e_jump = 1'b0; e_jaddr = RESET_PC; e_busy = acc;
      if (ops.size() != 0) begin
         e_busy = 1'b1;
         o = ops[0];
         if (o.kind == K_JMP_TRAP || o.kind == K_JMP_MRET) begin
            e_jump   = 1'b1;
            e_jaddr  = (o.kind == K_JMP_MRET) ? mepc_r : (mtvec_r & 32'hFFFF_FFFC);
            consumed = 1'b1;
         end else if (!exu_csr_we_i) begin
            e_we   = 1'b1;
            e_addr = o.addr;
            if (o.kind == K_WR)           e_dat = o.dat;
            else if (o.kind == K_WR_TRAP) e_dat = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
            else                          e_dat = (ms & ~32'h08) | 32'h80 | (ms[7] ? 32'h08 : 32'h0);
            consumed = 1'b1;
         end
      end
      if (model_on) begin
         n_cmp++;
         if (csr_we_o !== e_we || csr_waddr_o !== e_addr || csr_wdata_o !== e_dat ||
             busy_o !== e_busy || jump_o !== e_jump || jump_addr_o !== e_jaddr) begin
            n_bad++;
            $display("FAIL cycle_check cyc=%0d got we=%b a=%h d=%h busy=%b j=%b ja=%h want we=%b a=%h d=%h busy=%b j=%b ja=%h",
                     cyc, csr_we_o, csr_waddr_o, csr_wdata_o, busy_o, jump_o, jump_addr_o,
                     e_we, e_addr, e_dat, e_busy, e_jump, e_jaddr);
         end
      end
      if (!rst_n) begin
         ops.delete();
         model_on = 1'b1;
      end else if (model_on) begin
         if (consumed) void'(ops.pop_front());
         if (acc && is_mret) begin
            ops.push_back('{K_WR_MRET, 32'h300, 32'h0});
            ops.push_back('{K_JMP_MRET, 32'h0, 32'h0});
         end else if (acc) begin
            ops.push_back('{K_WR, 32'h341, inst_pc_i});
            ops.push_back('{K_WR, 32'h342, cause});
            ops.push_back('{K_WR_TRAP, 32'h300, 32'h0});
            ops.push_back('{K_JMP_TRAP, 32'h0, 32'h0});
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_wr(input string name, input logic [31:0] addr, input logic [31:0] dat);
      chk({name, "_we"}, 32'(csr_we_o), 32'h1);
      chk({name, "_addr"}, csr_waddr_o, addr);
      chk({name, "_data"}, csr_wdata_o, dat);
   endtask

   task automatic preset(input logic [31:0] ms, input logic [31:0] mie, input logic [31:0] tv,
                         input logic [31:0] ep);
      p_ms = ms; p_mie = mie; p_mtvec = tv; p_mepc = ep;
      preset_req = 1'b1;
      step;
      preset_req = 1'b0;
   endtask

   task automatic clear_ev;
      inst_ecall_i = 1'b0; inst_ebreak_i = 1'b0; inst_mret_i = 1'b0; irq_i = 1'b0;
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
      timer_irq_i = 1'b0;
`endif
   endtask

   initial begin
      rst_n = 1'b0; clear_ev(); inst_pc_i = 32'h0; exu_csr_we_i = 1'b0; exu_dat = 32'h0;
      preset_req = 1'b0; p_ms = 0; p_mie = 0; p_mtvec = 0; p_mepc = 0;
      mtvec_r = 0; mepc_r = 0; mstatus_r = 0; mie_r = 0; mcause_r = 0;
      repeat (3) step;
      chk("rst_we", 32'(csr_we_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_jump", 32'(jump_o), 32'h0);
      chk("rst_jaddr", jump_addr_o, RESET_PC);
      rst_n = 1'b1;
      step;

      // ecall: three writes then jump to aligned mtvec at N+4
      preset(32'h8, 32'h0, 32'h205, 32'h0);
      inst_pc_i = 32'h100; inst_ecall_i = 1'b1; #1;
      chk("ecall_busy_same_cycle", 32'(busy_o), 32'h1);
      step; clear_ev();
      chk_wr("ecall_mepc", 32'h341, 32'h100);
      step; chk_wr("ecall_mcause", 32'h342, 32'd11);
      step; chk_wr("ecall_mstatus", 32'h300, 32'h80);
      step; chk("ecall_jump", 32'(jump_o), 32'h1); chk("ecall_jaddr", jump_addr_o, 32'h204);
      step; chk("ecall_idle_busy", 32'(busy_o), 32'h0);

      // external irq enabled
      preset(32'h8, 32'h800, 32'h205, 32'h0);
      inst_pc_i = 32'h40; irq_i = 1'b1;
      step; chk_wr("irq_mepc", 32'h341, 32'h40);
      step; chk_wr("irq_mcause", 32'h342, 32'h8000_000B);
      repeat (4) step;
      chk("irq_no_reentry", 32'(busy_o), 32'h0);
      preset(32'h8, 32'h0, 32'h205, 32'h0);
      step; chk("irq_masked_busy", 32'(busy_o), 32'h0);
      irq_i = 1'b0;

      // mret
      preset(32'h80, 32'h0, 32'h205, 32'h144);
      inst_mret_i = 1'b1;
      step; clear_ev(); chk_wr("mret_mstatus", 32'h300, 32'h88);
      step; chk("mret_jump", 32'(jump_o), 32'h1); chk("mret_jaddr", jump_addr_o, 32'h144);
      step; chk("mret_idle", 32'(busy_o), 32'h0);

      // exu holds the port for two cycles during the mcause write
      preset(32'h8, 32'h0, 32'h205, 32'h0);
      inst_pc_i = 32'h180; inst_ecall_i = 1'b1;
      step; clear_ev();
      step; exu_csr_we_i = 1'b1; exu_dat = 32'h8; #1; chk("stall_we_1", 32'(csr_we_o), 32'h0);
      step; #1; chk("stall_we_2", 32'(csr_we_o), 32'h0);
      step; exu_csr_we_i = 1'b0; #1; chk_wr("stall_mcause", 32'h342, 32'd11);
      step; chk_wr("stall_mstatus", 32'h300, 32'h80);
      step; chk("stall_jump_n6", 32'(jump_o), 32'h1);
      step;

      // simultaneous ecall + mret + irq: ecall wins
      preset(32'h8, 32'h800, 32'h205, 32'h0);
      inst_pc_i = 32'h300; inst_ecall_i = 1'b1; inst_mret_i = 1'b1; irq_i = 1'b1;
      step; clear_ev(); chk_wr("prio_mepc", 32'h341, 32'h300);
      step; chk_wr("prio_mcause", 32'h342, 32'd11);
      repeat (4) step;

      // reset while in the mcause write
      preset(32'h8, 32'h0, 32'h205, 32'h0);
      inst_pc_i = 32'h200; inst_ecall_i = 1'b1;
      step; clear_ev();
      step; rst_n = 1'b0;
      step; rst_n = 1'b1; #1;
      chk("abort_we", 32'(csr_we_o), 32'h0);
      chk("abort_busy", 32'(busy_o), 32'h0);
      chk("abort_jaddr", jump_addr_o, RESET_PC);
      for (int k = 0; k < 4; k++) begin
         step; chk("abort_no_jump", 32'(jump_o), 32'h0);
      end

`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
      preset(32'h8, 32'h80, 32'h205, 32'h0);
      timer_irq_i = 1'b1;
      step; clear_ev(); step; chk_wr("timer_mcause", 32'h342, 32'h8000_0007);
      repeat (4) step;
      preset(32'h8, 32'h880, 32'h205, 32'h0);
      timer_irq_i = 1'b1; irq_i = 1'b1;
      step; clear_ev(); step; chk_wr("ext_timer_mcause", 32'h342, 32'h8000_000B);
      repeat (4) step;
`endif

      for (int i = 0; i < 3000; i++) begin
         inst_ecall_i  = ($urandom_range(0, 15) == 0);
         inst_ebreak_i = ($urandom_range(0, 15) == 0);
         inst_mret_i   = ($urandom_range(0, 15) == 0);
         inst_pc_i     = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) irq_i = ~irq_i;
`ifdef CSR_TRAP_SEQ_TIMER_IRQ_EN
         if ($urandom_range(0, 9) == 0) timer_irq_i = ~timer_irq_i;
`endif
         exu_csr_we_i = ($urandom_range(0, 4) == 0);
         exu_dat      = $urandom;
         rst_n        = ($urandom_range(0, 99) != 0);
         preset_req   = (i % 64 == 0);
         p_ms = $urandom; p_mie = $urandom; p_mtvec = $urandom; p_mepc = $urandom;
         step;
      end
      preset_req = 1'b0;
      step;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
